// File: rtl/serial_mux_adder.sv
// Bit-serial adder: one mux-based full-adder step per clock, LSB first, with a carry flip-flop.
// Optional macro SERIAL_ADD_SUB_EN adds a 'sub' port for two's-complement subtraction.
module serial_mux_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [7:0] SUM_PAT   = 8'b1001_0110;
    localparam logic [7:0] CARRY_PAT = 8'b1110_1000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] acc_sr;
    logic             c_ff;
    logic [CW-1:0]    cnt;
    logic [2:0]       sel;
    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

    // Full adder built as two 8:1 muxes indexed by {a,b,c}
    always_comb begin
        sel  = {a_sr[0], b_sr[0], c_ff};
        fa_s = SUM_PAT[sel];
        fa_c = CARRY_PAT[sel];
    end

`ifdef SERIAL_ADD_SUB_EN
    // a - b computed as a + ~b + 1
    always_comb begin
        b_load = sub ? ~b_in : b_in;
        c_load = sub ? 1'b1 : cin;
    end
`else
    always_comb begin
        b_load = b_in;
        c_load = cin;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            acc_sr <= '0;
            c_ff   <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a_in;
                        b_sr  <= b_load;
                        c_ff  <= c_load;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_SHIFT;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    c_ff   <= fa_c;
                    a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                    acc_sr <= {fa_s, acc_sr[WIDTH-1:1]};
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // Result registers see only the completed word, never partial bits
                        sum   <= {fa_s, acc_sr[WIDTH-1:1]};
                        cout  <= fa_c;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_mux_adder.sv
// Scoreboard bench for serial_mux_adder: driver queues expected results, monitor checks on done.
module tb_serial_mux_adder;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin;
`ifdef SERIAL_ADD_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    serial_mux_adder #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a_in (a_in),
        .b_in (b_in),
        .cin  (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub  (sub),
`endif
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout)
    );

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        int unsigned  cyc;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    int unsigned n_total = 0;
    int unsigned n_pass = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: pops an expectation on every done and tracks busy length and sum stability
    initial begin : monitor
        int unsigned  busy_run;
        logic         prev_done;
        logic [W-1:0] last_sum;
        logic         last_cout;
        exp_t         e;
        busy_run = 0; prev_done = 1'b0; last_sum = '0; last_cout = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_run = 0; prev_done = 1'b0; last_sum = '0; last_cout = 1'b0;
            end else begin
                if (done) begin
                    check("done_expected", 32'(q.size() != 0), 32'd1);
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        check("sum", 32'(sum), 32'(e.s));
                        check("cout", 32'(cout), 32'(e.c));
                        // edges from the accepting edge to the DONE-entry edge
                        check("latency", cyc - e.cyc, W);
                        check("busy_cycles", busy_run, W);
                        check("busy_low_at_done", 32'(busy), 32'd0);
                        check("done_single_pulse", 32'(prev_done), 32'd0);
                    end
                    last_sum = sum; last_cout = cout; busy_run = 0;
                end else if (busy) begin
                    busy_run++;
                    check("sum_hold", 32'({cout, sum}), 32'({last_cout, last_sum}));
                end
                prev_done = done;
            end
        end
    end

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                      input logic [W-1:0] es, input logic ec);
        start = 1'b1; a_in = a; b_in = b; cin = c;
        @(posedge clk); #1;
        q.push_back('{s: es, c: ec, cyc: cyc});
        start = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60; i++) begin
            if (q.size() == 0) break;
            @(posedge clk); #1;
        end
        check("drain", q.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin : driver
        logic found;
        rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        sub = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'h00);
        check("rst_cout", 32'(cout), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("idle_busy", 32'(busy), 32'd0);

        op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
        wait_drain();
        op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        wait_drain();
        op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        wait_drain();

        // start while busy must be ignored
        op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; a_in = 8'hAA; b_in = 8'h55;
        @(posedge clk); #1;
        start = 1'b0;
        wait_drain();
        repeat (3) @(posedge clk);
        #1;

        // reset mid-operation: aborted op has no expectation queued
        start = 1'b1; a_in = 8'h0F; b_in = 8'h01; cin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_sum", 32'(sum), 32'h00);
        check("abort_cout", 32'(cout), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        repeat (W + 3) @(posedge clk);
        #1;

        // back-to-back: start held high through done starts the second op
        start = 1'b1; a_in = 8'h0F; b_in = 8'h01; cin = 1'b0;
        @(posedge clk); #1;
        q.push_back('{s: 8'h10, c: 1'b0, cyc: cyc});
        a_in = 8'h80; b_in = 8'h80;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(posedge clk); #1;
            if (done) found = 1'b1;
        end
        check("b2b_first_done_seen", 32'(found), 32'd1);
        @(posedge clk); #1;
        q.push_back('{s: 8'h00, c: 1'b1, cyc: cyc});
        start = 1'b0;
        wait_drain();

`ifdef SERIAL_ADD_SUB_EN
        sub = 1'b1;
        op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b1);
        wait_drain();
        op(8'h01, 8'h02, 1'b0, 8'hFF, 1'b0);
        wait_drain();
        sub = 1'b0;
`endif

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
